// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the default widths and the controller state encoding.
// No logic lives here.
package seq_div_pkg;

  localparam int DEF_N  = 32;         // divisor / remainder width
  localparam int DEF_CW = 7;          // iteration counter width, 2^CW > 2N
  localparam int QW     = 2 * DEF_N;  // dividend / quotient width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_div_bin_if.sv
// Start/valid handshake and operand/result bus of the divider.
// The requester drives start and operands; the divider returns results and status.
// Results are held until the next accepted start.
interface seq_div_bin_if #(
  parameter int N = 32
) ();

  logic           start;
  logic [2*N-1:0] dvdnd;
  logic [N-1:0]   dvsor;
  logic [2*N-1:0] quot;
  logic [N-1:0]   rmndr;
  logic           valid;
  logic           busy;
  logic           dz;

  modport master (
    output start, dvdnd, dvsor,
    input  quot, rmndr, valid, busy, dz
  );

  modport slave (
    input  start, dvdnd, dvsor,
    output quot, rmndr, valid, busy, dz
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and trial-subtract.
// Purely combinational, zero latency.
// No handshake; usable as one stage of an unrolled array divider.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   p,       // partial remainder, always < divisor
  input  logic         nbit,    // next dividend bit, MSB first
  input  logic [N-1:0] d,       // divisor
  output logic [N:0]   p_next,
  output logic         qbit
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  // Trial subtraction one bit wider than the operand so the top bit is the borrow.
  always_comb begin
    shifted = {p, nbit};
    trial   = shifted - {2'b00, d};
    qbit    = ~trial[N+1];
    p_next  = qbit ? trial[N:0] : shifted[N:0];
  end

endmodule

// File: rtl/seq_div_bin.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Latency 2N cycles from accept to valid; divide-by-zero answers in 1 cycle.
// start is only honoured in IDLE or DONE; it is ignored while busy.
module seq_div_bin
  import seq_div_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic          clock,
  input  logic          reset,
  seq_div_bin_if.slave  bus
);

  state_t         state_q;
  state_t         state_d;
  logic           accept;
  logic           finish;

  logic [N:0]     p_q;      // partial remainder
  logic [2*N-1:0] q_q;      // dividend shifting out, quotient shifting in
  logic [N-1:0]   d_q;      // captured divisor
  logic [CW-1:0]  count_q;  // remaining steps

  logic [N:0]     p_next;
  logic           qbit;
  logic [2*N-1:0] q_next;

  div_step #(.N(N)) u_step (
    .p      (p_q),
    .nbit   (q_q[2*N-1]),
    .d      (d_q),
    .p_next (p_next),
    .qbit   (qbit)
  );

  assign q_next = {q_q[2*N-2:0], qbit};

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus accept/finish strobes for the datapath.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = (bus.dvsor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (count_q == CW'(1)) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      count_q   <= '0;
      bus.quot  <= '0;
      bus.rmndr <= '0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.dz    <= 1'b0;
    end else if (accept) begin
      d_q       <= bus.dvsor;
      bus.valid <= 1'b0;
      bus.dz    <= 1'b0;
      if (bus.dvsor != '0) begin
        p_q      <= '0;
        q_q      <= bus.dvdnd;
        count_q  <= CW'(2 * N);
        bus.busy <= 1'b1;
      end else begin
        // Divide by zero: saturated quotient, low dividend half as remainder.
        bus.quot  <= '1;
        bus.rmndr <= bus.dvdnd[N-1:0];
        bus.dz    <= 1'b1;
        bus.valid <= 1'b1;
      end
    end else if (state_q == CALC) begin
      p_q     <= p_next;
      q_q     <= q_next;
      count_q <= count_q - CW'(1);
      if (finish) begin
        bus.quot  <= q_next;
        bus.rmndr <= p_next[N-1:0];
        bus.valid <= 1'b1;
        bus.busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_div_bin.sv
// Self-checking bench for seq_div_bin against a plain-arithmetic model.
// Directed cases plus randomized operands.
// Inputs change #1 after rising edges, outputs are sampled there too.
module tb_seq_div_bin;
  import seq_div_pkg::*;

  localparam int N = DEF_N;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  seq_div_bin_if #(.N(N)) bus ();

  seq_div_bin #(.N(N), .CW(DEF_CW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start for exactly one rising edge, then scramble them.
  task automatic accept_op(input logic [63:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dvdnd = a;
    bus.dvsor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dvdnd = {$urandom, $urandom};
    bus.dvsor = $urandom;
  endtask

  // Count edges until valid, bounded; also count cycles where busy was low.
  task automatic wait_valid(output int k, output int busy_low);
    k = 0;
    busy_low = 0;
    while (!bus.valid && k < 200) begin
      if (!bus.busy) busy_low++;
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] a, input logic [31:0] b);
    logic [63:0] eq;
    logic [31:0] er;
    logic [63:0] a64;
    a64 = a;
    if (b == 0) begin
      eq = 64'hFFFF_FFFF_FFFF_FFFF;
      er = a64[31:0];
    end else begin
      eq = a / {32'd0, b};
      er = 32'(a % {32'd0, b});
    end
    chk({tag, "_quot"}, bus.quot, eq);
    chk({tag, "_rmndr"}, {32'd0, bus.rmndr}, {32'd0, er});
    chk({tag, "_dz"}, {63'd0, bus.dz}, {63'd0, (b == 0)});
    chk({tag, "_valid"}, {63'd0, bus.valid}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b);
    int k;
    int bl;
    accept_op(a, b);
    if (b != 0) chk({tag, "_busy_start"}, {63'd0, bus.busy}, 64'd1);
    wait_valid(k, bl);
    chk({tag, "_latency"}, 64'(k), (b == 0) ? 64'd0 : 64'(2 * N));
    chk({tag, "_busy_low"}, 64'(bl), 64'd0);
    chk({tag, "_busy_done"}, {63'd0, bus.busy}, 64'd0);
    check_result(tag, a, b);
  endtask

  initial begin
    int k;
    int bl;
    logic [63:0] ra;
    logic [31:0] rb;
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.dvdnd = '0;
    bus.dvsor = '0;

    // Outputs during reset.
    #12;
    chk("rst_quot", bus.quot, 64'd0);
    chk("rst_rmndr", {32'd0, bus.rmndr}, 64'd0);
    chk("rst_valid", {63'd0, bus.valid}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_dz", {63'd0, bus.dz}, 64'd0);
    #13 rst = 1'b1;

    // 100/7 with a stray start (9/2) during CALC, which must be ignored.
    accept_op(64'd100, 32'd7);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b1;
    bus.dvdnd = 64'd9;
    bus.dvsor = 32'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_valid(k, bl);
    chk("ignore_latency", 64'(k + 11), 64'(2 * N));
    chk("ignore_busy_low", 64'(bl), 64'd0);
    chk("ignore_quot", bus.quot, 64'd14);
    chk("ignore_rmndr", {32'd0, bus.rmndr}, 64'd2);
    chk("ignore_dz", {63'd0, bus.dz}, 64'd0);

    run_op("mul_rt", 64'd65, 32'd5);
    run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    chk("max_quot_lit", bus.quot, 64'h0000_0001_0000_0001);
    run_op("dz", 64'h1234_5678, 32'd0);
    chk("dz_rmndr_lit", {32'd0, bus.rmndr}, 64'h1234_5678);

    // Asynchronous reset mid-period, 30 cycles into CALC.
    accept_op(64'd100, 32'd7);
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", {63'd0, bus.valid}, 64'd0);
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_quot", bus.quot, 64'd0);
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_idle_valid", {63'd0, bus.valid}, 64'd0);
    run_op("post_rst", 64'd200, 32'd9);
    chk("post_rst_quot_lit", bus.quot, 64'd22);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.start = 1'b1;
    bus.dvdnd = 64'd1000;
    bus.dvsor = 32'd10;
    @(posedge clk);
    #1;
    bus.dvdnd = 64'd7;
    bus.dvsor = 32'd8;
    wait_valid(k, bl);
    chk("b2b1_latency", 64'(k), 64'(2 * N));
    check_result("b2b1", 64'd1000, 32'd10);
    @(posedge clk);
    #1;
    chk("b2b1_pulse", {63'd0, bus.valid}, 64'd0);
    bus.start = 1'b0;
    wait_valid(k, bl);
    chk("b2b2_latency", 64'(k), 64'(2 * N));
    check_result("b2b2", 64'd7, 32'd8);
    @(posedge clk);
    #1;
    chk("b2b2_hold", {63'd0, bus.valid}, 64'd1);

    // Randomized operands, including small, full-width and zero divisors.
    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      case (i % 5)
        0: rb = 32'($urandom_range(1, 15));
        1: rb = $urandom;
        2: rb = 32'($urandom_range(1, 65535));
        3: begin
          rb = $urandom;
          ra = ra >> $urandom_range(16, 63);
        end
        default: rb = (i == 9) ? 32'd0 : ($urandom | 32'h8000_0000);
      endcase
      run_op("rand", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_div_bin.md
Name: seq_div_bin

Overview:
- Sequential restoring binary divider; the inverse of the array multiplier.
- Takes a 2N-bit dividend (such as a multiplier product) and an N-bit divisor. Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath, using the same start/valid handshake.
- Used for round-trip checking of products and for general unsigned division.

Parameters:
- N, 32, divisor and remainder width; dividend and quotient are 2N bits.
- CW, 7, iteration counter width (must satisfy 2^CW > 2N).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (reset=0 resets, independent of clock).
- start  input  1  request; sampled on rising edge only in IDLE or DONE.
- dvdnd  input  2N  unsigned dividend; captured on an accepted start.
- dvsor  input  N  unsigned divisor; captured on an accepted start.
- quot  output  2N  quotient; registered.
- rmndr  output  N  remainder; registered.
- valid  output  1  high while quot/rmndr hold the result of the last accepted start.
- busy  output  1  high in CALC.
- dz  output  1  divide-by-zero flag; meaningful only while valid=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; quot=0, rmndr=0, valid=0, busy=0, dz=0; internal registers cleared. Holds until reset=1. Reset mid-CALC aborts the operation with no result.
- States and transitions:
  - IDLE: start=1 → accept.
  - CALC: iterate; start ignored.
  - DONE: valid=1, outputs held; start=1 → accept.
- Accept (edge E0):
  - Capture operands; valid←0, dz←0.
  - If dvsor≠0: partial remainder P (N+1 bits)←0, shift register Q←dvdnd, count←2N, busy←1, go to CALC.
  - If dvsor=0: quot←all ones, rmndr←dvdnd[N-1:0], dz←1, valid←1, go to DONE. valid is high after E0 (1-cycle latency).
- CALC, each edge (restoring step):
  - T = {P[N-1:0], Q[2N-1]} − {1'b0, D}.
  - If T is non-negative: P←T, Q←{Q[2N-2:0],1}; else P←{P[N-1:0],Q[2N-1]}, Q←{Q[2N-2:0],0}.
  - count←count−1.
- On the edge where count goes 1→0:
  - quot←final Q, rmndr←final P[N-1:0], valid←1, busy←0, go to DONE.
  - Normal latency: valid rises after edge E0+2N (64 cycles for N=32).
- Invariant: quot*dvsor + rmndr = dvdnd and rmndr < dvsor. Never overflows, since the quotient is 2N bits.
- start held high continuously: each pass through DONE lasts exactly one cycle before a new accept (back-to-back operation). valid pulses for one cycle per result.
- Operand inputs may change freely after accept; captured copies are used.
- All arithmetic is unsigned. No X on outputs after reset.

Decomposition:
- Package seq_div_pkg:
  - N and CW defaults.
  - State enum {IDLE, CALC, DONE}, 2-bit encoding.
  - Localparam QW = 2N.
- Sub-module div_step:
  - Combinational; inputs P, next dividend bit, divisor.
  - Outputs next P and quotient bit.
  - Instantiated once in seq_div_bin; reusable by a future unrolled array divider.

Test Plan:
- Reset=0 for 25 ns, then start=1, dvdnd=100, dvsor=7 → valid after 64 cycles, quot=14, rmndr=2, dz=0; all outputs 0 during reset.
- Round-trip of the multiplier case: dvdnd=65 (13×5), dvsor=5 → quot=13, rmndr=0. Also dvdnd=0xFFFFFFFF_FFFFFFFF, dvsor=0xFFFFFFFF → quot=0x00000001_00000001, rmndr=0.
- dvdnd=0x12345678, dvsor=0 → valid one cycle after accept, dz=1, quot=0xFFFFFFFF_FFFFFFFF, rmndr=0x12345678.
- start pulsed with new operands (dvdnd=9, dvsor=2) during CALC of 100/7 → ignored; result stays 14 r2; busy=1 throughout CALC.
- Drive reset=0 asynchronously (mid-clock-period) 30 cycles into CALC → immediately state IDLE, valid=0, busy=0. Next start with 200/9 → quot=22, rmndr=2.
- start held high, operands 1000/10 then 7/8 → consecutive results 100 r0, then 0 r7. Each valid lasts one cycle; each latency is 2N edges.
